// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants for the pipeline stall/flush controller
//                (sequencer state encoding, register-address width).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  // Register-file address width
  localparam int REG_AW = 5;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use compare between the load in EX and
//                the source registers of the instruction in ID. Register 0
//                is hard-wired zero and never creates a dependency.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  output logic              load_use
);

  // Load in EX writes a register the ID instruction is about to read
  always_comb begin
    load_use = idex_mem_read
             && (idex_rt != '0)
             && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Handles load-use bubbles, taken-branch flushes and the
//                request/acknowledge handshake with a multi-cycle data
//                memory, freezing the pipeline while an access is pending.
//                Counts frozen cycles and flags a stuck memory access.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              idex_memRead_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              branch_taken_i,
  input  logic              exmem_memRead_i,
  input  logic              exmem_memWrite_i,
  input  logic              dmem_ack_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_hold_o,
  output logic              memwb_bubble_o,
  output logic              dmem_req_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Wide enough to hold MEM_TIMEOUT itself
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] C_TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            w_memop;
  logic            w_lu;
  logic            w_freeze;
  logic            w_req;

  assign w_memop = exmem_memRead_i | exmem_memWrite_i;

  hazard_detect u_hazard_detect (
    .idex_mem_read (idex_memRead_i),
    .idex_rt       (idex_rt_i),
    .ifid_rs       (ifid_rs_i),
    .ifid_rt       (ifid_rt_i),
    .load_use      (w_lu)
  );

  // Next-state, timeout counter and freeze decision for the memory handshake
  always_comb begin
    w_state_nxt  = r_state;
    w_to_cnt_nxt = r_to_cnt;
    w_freeze     = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req = w_memop;
        // A same-cycle ack is a single-cycle hit: no freeze at all
        if (w_memop && !dmem_ack_i) begin
          w_freeze     = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          w_to_cnt_nxt = TO_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        w_req = 1'b1;
        // The ack cycle itself is not frozen; the access retires here
        if (dmem_ack_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_freeze = 1'b1;
          if (r_to_cnt >= C_TO_LIMIT) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          end
        end
      end
      default: begin
        // ERROR (and any unused code) freezes until reset
        w_freeze    = 1'b1;
        w_state_nxt = ST_ERROR;
      end
    endcase
  end

  // Pipeline-register control: reset, then freeze, then load-use, then branch
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    dmem_req_o     = w_req;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
      dmem_req_o     = 1'b0;
    end else if (w_freeze) begin
      // ID/EX holds implicitly because its enable follows ifid_write_o
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      exmem_hold_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (w_lu) begin
      // Load-use beats a taken branch: branch operands are not ready yet
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Sequencer state and memory timeout counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_cnt <= w_to_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (!pc_write_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign err_o       = (r_state == ST_ERROR);
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl: directed
//                scenarios followed by randomized traffic, compared against
//                a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 8;
  localparam int SAT     = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld;
  logic [4:0]    ex_rt, id_rs, id_rt;
  logic          br, mrd, mwr, ack;
  logic          pc_w, ifid_w, ifid_fl, idex_bb, exmem_h, memwb_bb, req, err;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model: waiting on memory, cycles spent waiting, errored, stall count
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_stalls;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .idex_memRead_i   (ld),
    .idex_rt_i        (ex_rt),
    .ifid_rs_i        (id_rs),
    .ifid_rt_i        (id_rt),
    .branch_taken_i   (br),
    .exmem_memRead_i  (mrd),
    .exmem_memWrite_i (mwr),
    .dmem_ack_i       (ack),
    .pc_write_o       (pc_w),
    .ifid_write_o     (ifid_w),
    .ifid_flush_o     (ifid_fl),
    .idex_bubble_o    (idex_bb),
    .exmem_hold_o     (exmem_h),
    .memwb_bubble_o   (memwb_bb),
    .dmem_req_o       (req),
    .err_o            (err),
    .stall_cnt_o      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit i_ld, input int i_ert, input int i_rs, input int i_rt,
                        input bit i_br, input bit i_rd, input bit i_wr, input bit i_ack);
    ld = i_ld; ex_rt = 5'(i_ert); id_rs = 5'(i_rs); id_rt = 5'(i_rt);
    br = i_br; mrd = i_rd; mwr = i_wr; ack = i_ack;
  endtask

  // Check outputs against the model mid-cycle, then advance one clock
  task automatic step();
    bit memop, lu, frz;
    bit e_pc, e_ifw, e_fl, e_idb, e_hold, e_mwb, e_req;
    #3;
    memop = mrd | mwr;
    lu    = ld && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    frz   = m_err || (m_wait && !ack) || (!m_wait && memop && !ack);
    {e_pc, e_ifw, e_fl, e_idb, e_hold, e_mwb, e_req} = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (rst) begin
      {e_pc, e_ifw, e_fl, e_idb, e_hold, e_mwb, e_req} = 7'b0001010;
    end else begin
      e_req = !m_err && (m_wait || memop);
      if (frz)            {e_pc, e_ifw, e_hold, e_mwb} = 4'b0011;
      else if (lu)        {e_pc, e_ifw, e_idb} = 3'b001;
      else if (br)        e_fl = 1'b1;
    end
    chk("ctl", 32'({pc_w, ifid_w, ifid_fl, idex_bb, exmem_h, memwb_bb, req}),
               32'({e_pc, e_ifw, e_fl, e_idb, e_hold, e_mwb, e_req}));
    chk("err", 32'(err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_wcnt = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (!e_pc && m_stalls < SAT) m_stalls++;
      if (m_err) begin
        // stays errored until reset
      end else if (m_wait) begin
        if (ack)                    m_wait = 0;
        else if (m_wcnt >= TIMEOUT) begin m_wait = 0; m_err = 1; end
        else                        m_wcnt++;
      end else if (memop && !ack) begin
        m_wait = 1; m_wcnt = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    m_wait = 0; m_wcnt = 0; m_err = 0; m_stalls = 0;

    // Reset outputs
    step();
    chk("rst_stall0", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    idle();

    // Load-use: lw $2 in EX, ID reads rs=2
    set_in(1, 2, 2, 7, 0, 0, 0, 0);
    #3; chk("lu_pc_write", 32'(pc_w), 32'd0); chk("lu_bubble", 32'(idex_bb), 32'd1); #1;
    step();
    set_in(0, 2, 2, 7, 0, 0, 0, 0);
    #3; chk("lu_next_pc_write", 32'(pc_w), 32'd1); #1;
    step();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Register 0 never stalls
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #3; chk("r0_pc_write", 32'(pc_w), 32'd1); #1;
    step();

    // Taken branch, no hazard
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    #3; chk("br_flush", 32'(ifid_fl), 32'd1); chk("br_pc_write", 32'(pc_w), 32'd1); #1;
    step();
    idle();

    // Branch + load-use together, then branch alone
    set_in(1, 3, 4, 3, 1, 0, 0, 0);
    #3; chk("brlu_flush", 32'(ifid_fl), 32'd0); #1;
    step();
    set_in(0, 3, 4, 3, 1, 0, 0, 0);
    #3; chk("brlu_next_flush", 32'(ifid_fl), 32'd1); #1;
    step();
    idle();

    // Memory load acknowledged after three frozen cycles
    s0 = int'(stall_cnt);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      #3; chk("mw_req", 32'(req), 32'd1); chk("mw_hold", 32'(exmem_h), 32'd1); #1;
      step();
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    #3; chk("mw_ack_pc_write", 32'(pc_w), 32'd1); chk("mw_ack_req", 32'(req), 32'd1); #1;
    step();
    chk("mw_stalls", 32'(int'(stall_cnt) - s0), 32'd3);
    idle();

    // Single-cycle store hit: no freeze
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #3; chk("hit_pc_write", 32'(pc_w), 32'd1); #1;
    step();
    idle();

    // Timeout: ack never arrives
    for (int i = 0; i < 1 + TIMEOUT; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      step();
    end
    chk("to_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 0, 1);
      #3; chk("to_frozen_pc", 32'(pc_w), 32'd0); chk("to_req", 32'(req), 32'd0); #1;
      step();
    end
    rst = 1'b1; idle(); rst = 1'b0;
    chk("to_rst_err", 32'(err), 32'd0);
    chk("to_rst_stall", 32'(stall_cnt), 32'd0);
    idle();

    // Reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      step();
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    #3; chk("mid_rst_req", 32'(req), 32'd0); #1;
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3; chk("mid_rst_run_pc", 32'(pc_w), 32'd1); chk("mid_rst_run_req", 32'(req), 32'd0); #1;
    step();

    // Stall counter saturation while stuck in ERROR
    for (int i = 0; i < SAT + 20; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0, 0);
      step();
    end
    chk("stall_sat", 32'(stall_cnt), 32'(SAT));
    rst = 1'b1; idle(); rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and taken branches resolved in ID.
- Runs the request/acknowledge handshake with a multi-cycle data memory; freezes the pipeline until the access completes.
- Tracks frozen cycles and flags a memory timeout.

Parameters:
- MEM_TIMEOUT, 64: maximum cycles in MEM_WAIT before entering ERROR.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- idex_memRead_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  destination register of the instruction in EX.
- ifid_rs_i  in  5  rs field of the instruction in ID.
- ifid_rt_i  in  5  rt field of the instruction in ID.
- branch_taken_i  in  1  branch in ID resolved taken this cycle.
- exmem_memRead_i  in  1  EX/MEM register holds a load.
- exmem_memWrite_i  in  1  EX/MEM register holds a store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  IF/ID register loads a NOP.
- idex_bubble_o  out  1  ID/EX register loads zeroed control bits.
- exmem_hold_o  out  1  EX/MEM register keeps its contents.
- memwb_bubble_o  out  1  MEM/WB register loads zeroed control bits.
- dmem_req_o  out  1  data memory request.
- err_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  saturating count of frozen cycles.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=RUN, timeout counter=0, stall_cnt_o=0, err_o=0.
  - While rst_i is high: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, exmem_hold_o=0, memwb_bubble_o=1, dmem_req_o=0.
  - Reset has priority over every event, including during MEM_WAIT.
- Internal signals:
  - memop = exmem_memRead_i | exmem_memWrite_i.
  - lu = idex_memRead_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i).
- States: RUN, MEM_WAIT, ERROR. Outputs are combinational from state and inputs.
- RUN, memop & dmem_ack_i (single-cycle hit): no freeze; stay in RUN.
- RUN, memop & !dmem_ack_i: freeze; next state MEM_WAIT, timeout counter set to 1.
- Freeze means:
  - pc_write_o=0, ifid_write_o=0, exmem_hold_o=1, memwb_bubble_o=1.
  - idex_bubble_o=0: ID/EX holds, because its load enable is tied to ifid_write_o.
  - lu and branch_taken_i are ignored; they are re-evaluated once the freeze ends.
- dmem_req_o = (RUN & memop) | MEM_WAIT.
- MEM_WAIT, dmem_ack_i=1:
  - That cycle is not frozen: outputs follow the RUN rules, with memop treated as already acknowledged.
  - Next state RUN. The access completes exactly once.
- MEM_WAIT, no ack:
  - Stay frozen; timeout counter increments.
  - When the counter reaches MEM_TIMEOUT, next state ERROR.
  - An ack arriving on the same cycle wins; ERROR is not entered.
- ERROR: permanent freeze, dmem_req_o=0, err_o=1. Leaves ERROR only on reset.
- RUN without a freeze:
  - lu=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; one bubble per hazard.
  - branch_taken_i=1 with lu=0: ifid_flush_o=1; PC and IF/ID write normally.
  - lu and branch_taken_i together: lu wins and the flush is suppressed, because branch operands are not yet valid and the branch re-resolves next cycle.
  - Default: all enables 1, all flush/bubble/hold 0.
- stall_cnt_o: +1 on each cycle with pc_write_o=0 and rst_i=0; saturates at all-ones.
- Register 0 never triggers a load-use stall.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2.
  - register-address width constant REG_AW=5.
- One natural sub-module: hazard_detect, the combinational lu compare. It is reusable by the forwarding unit.
- FSM and counters stay in the top module.

Test Plan:
- Load-use: lw $2 in EX (idex_memRead_i=1, idex_rt_i=2), ID reads rs=2 -> one cycle with pc_write_o=0, idex_bubble_o=1; the next cycle is normal; stall_cnt_o=1.
- Load with idex_rt_i=0 and ifid_rs_i=0 -> no stall.
- Branch: branch_taken_i=1, lu=0 -> ifid_flush_o=1 for exactly one cycle, pc_write_o=1.
- Branch and load-use in the same cycle -> no flush, bubble inserted; branch_taken_i=1 the following cycle produces the flush.
- Memory wait: exmem_memRead_i=1, ack after 3 cycles:
  - freeze for cycles 0–2 (three frozen cycles; the ack cycle is not frozen), dmem_req_o high throughout.
  - pipeline advances on the ack cycle; stall_cnt_o=3.
- Timeout with MEM_TIMEOUT=4, ack never arrives -> err_o=1 after 4 MEM_WAIT cycles, permanent freeze. Asserting rst_i for one cycle -> RUN, err_o=0, stall_cnt_o=0.
- Reset mid-MEM_WAIT -> RUN next cycle, dmem_req_o=0 during reset.
